// File: rtl/fractal_sync_rf_arbiter.sv
// fractal_sync_rf_arbiter: round-robin arbiter sharing a sync node's register-file request port
// between per-port input FIFOs, with a registered response demux back to the requesters.
module fractal_sync_rf_arbiter #(
   parameter int N_PORTS    = 2,
   parameter int FIFO_DEPTH = 2,
   parameter int ID_W       = 8,
   parameter int LVL_W      = 4,
   parameter int SRC_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [N_PORTS-1:0]              req_valid_i,
   output logic [N_PORTS-1:0]              req_ready_o,
   input  logic [N_PORTS-1:0][ID_W-1:0]    req_id_i,
   input  logic [N_PORTS-1:0][LVL_W-1:0]   req_lvl_i,
   output logic                            rf_req_valid_o,
   input  logic                            rf_req_ready_i,
   output logic [ID_W-1:0]                 rf_req_id_o,
   output logic [LVL_W-1:0]                rf_req_lvl_o,
   output logic [SRC_W-1:0]                rf_req_src_o,
   input  logic                            rf_rsp_valid_i,
   input  logic [SRC_W-1:0]                rf_rsp_src_i,
   input  logic [ID_W-1:0]                 rf_rsp_id_i,
   input  logic                            rf_rsp_sync_i,
   output logic [N_PORTS-1:0]              rsp_valid_o,
   output logic [N_PORTS-1:0][ID_W-1:0]    rsp_id_o,
   output logic [N_PORTS-1:0]              rsp_sync_o,
   output logic                            busy_o,
   output logic                            err_o
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int EW = ID_W + LVL_W;

   logic [N_PORTS-1:0][FIFO_DEPTH-1:0][EW-1:0] mem;
   logic [N_PORTS-1:0][PW-1:0] rd_ptr, wr_ptr;
   logic [N_PORTS-1:0][CW-1:0] cnt;
   logic [N_PORTS-1:0] empty, full, push, pop;
   logic [SRC_W-1:0] rr_q, grant_q, cand, grant;
   logic lock_q, found, hs;
   logic [SRC_W:0] rsp_src_ext;

   function automatic logic [SRC_W-1:0] wrap(input int v);
      return SRC_W'(v % N_PORTS);
   endfunction

   for (genvar p = 0; p < N_PORTS; p++) begin : g_port
      assign empty[p] = cnt[p] == '0;
      assign full[p]  = cnt[p] == CW'(FIFO_DEPTH);
      assign push[p]  = req_valid_i[p] & ~full[p];
      assign pop[p]   = hs && grant == SRC_W'(p);
   end

   assign req_ready_o = ~full;
   assign busy_o      = ~&empty;

   // Reverse scan so the port closest to rr_q is the last (winning) assignment.
   always_comb begin
      cand  = '0;
      found = 1'b0;
      for (int i = N_PORTS - 1; i >= 0; i--)
         if (!empty[wrap(int'(rr_q) + i)]) begin
            cand  = wrap(int'(rr_q) + i);
            found = 1'b1;
         end
   end

   assign grant          = lock_q ? grant_q : cand;
   assign rf_req_valid_o = lock_q | found;
   assign hs             = rf_req_valid_o & rf_req_ready_i;
   assign rf_req_src_o   = grant;
   assign {rf_req_id_o, rf_req_lvl_o} = mem[grant][rd_ptr[grant]];

   always_ff @(posedge clk_i)
      for (int p = 0; p < N_PORTS; p++)
         if (push[p]) mem[p][wr_ptr[p]] <= {req_id_i[p], req_lvl_i[p]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         cnt     <= '0;
         rr_q    <= '0;
         grant_q <= '0;
         lock_q  <= 1'b0;
      end else begin
         for (int p = 0; p < N_PORTS; p++) begin
            if (push[p]) wr_ptr[p] <= (wr_ptr[p] == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr[p] + 1'b1;
            if (pop[p]) rd_ptr[p] <= (rd_ptr[p] == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr[p] + 1'b1;
            if (push[p] != pop[p]) cnt[p] <= push[p] ? cnt[p] + 1'b1 : cnt[p] - 1'b1;
         end
         lock_q <= rf_req_valid_o & ~rf_req_ready_i;
         if (rf_req_valid_o & ~rf_req_ready_i) grant_q <= grant;
         if (hs) rr_q <= (grant == SRC_W'(N_PORTS - 1)) ? '0 : grant + 1'b1;
      end
   end

   assign rsp_src_ext = {1'b0, rf_rsp_src_i};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_valid_o <= '0;
         rsp_id_o    <= '0;
         rsp_sync_o  <= '0;
         err_o       <= 1'b0;
      end else begin
         rsp_valid_o <= '0;
         err_o       <= rf_rsp_valid_i && rsp_src_ext >= (SRC_W + 1)'(N_PORTS);
         if (rf_rsp_valid_i && rsp_src_ext < (SRC_W + 1)'(N_PORTS)) begin
            rsp_valid_o[rf_rsp_src_i] <= 1'b1;
            rsp_id_o[rf_rsp_src_i]    <= rf_rsp_id_i;
            rsp_sync_o[rf_rsp_src_i]  <= rf_rsp_sync_i;
         end
      end
   end
endmodule
